// File: rtl/spi_image_loader_pkg.sv
// Shared types and command codes for the SPI image loader.
package spi_img_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    CHECK = 2'd3
  } img_state_t;

  localparam logic [7:0] CMD_START = 8'hA5;
  localparam logic [7:0] CMD_CLEAR = 8'h5A;

endpackage

// File: rtl/spi_image_loader_buf.sv
// img_bit_buffer: bit-addressable pixel store with a byte-wide write port (MSB = lowest pixel),
// synchronous clear and a registered 1-bit read port.
module img_bit_buffer #(
  parameter int NPIX = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [$clog2(NPIX/8)-1:0] widx,
  input  logic [7:0]                wdata,
  input  logic                      clr,
  input  logic [$clog2(NPIX)-1:0]   raddr,
  output logic                      rdata
);
  logic [NPIX-1:0] mem;

  // Lane i of a written byte lands on pixel 8*widx+i, taken from data bit 7-i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (we) begin
      for (int i = 0; i < 8; i++) mem[{widx, 3'(i)}] <= wdata[3'(7 - i)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= 1'b0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_image_loader.sv
// spi_image_loader: waits for START on the SPI byte stream, unpacks one frame of 1-bit pixels,
// then holds it for the engine. SPI_IMG_CHECKSUM_EN adds a trailing XOR checksum byte.
module spi_image_loader
  import spi_img_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       spi_rx_data,
  input  logic                             byte_valid,
  output logic                             byte_taken,
  output logic                             rx_enable,
  output logic                             image_ready,
  input  logic                             img_consumed,
  output logic                             frame_err,
  input  logic [$clog2(IMG_W*IMG_H)-1:0]   rd_addr,
  output logic                             rd_data
);
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int IMG_BYTES = NPIX / 8;
  localparam int CW        = $clog2(IMG_BYTES);
`ifdef SPI_IMG_CHECKSUM_EN
  localparam img_state_t DONE_ST = CHECK;
`else
  localparam img_state_t DONE_ST = READY;
`endif

  img_state_t     state, state_nx;
  logic           live_q, taken_q, acc;
  logic [CW-1:0]  cnt;
  logic           start_cmd, buf_we, buf_clr;
  logic           is_start, is_clear, last_byte;
`ifdef SPI_IMG_CHECKSUM_EN
  logic [7:0]     xsum;
  logic           err_q, chk_bad;
`endif

  assign is_start  = (spi_rx_data == CMD_START);
  assign is_clear  = (spi_rx_data == CMD_CLEAR);
  assign last_byte = (cnt == CW'(IMG_BYTES - 1));

  // The holdoff on taken_q masks the receiver's trailing byte_valid cycle.
  assign acc         = live_q & byte_valid & ~taken_q & (state != READY);
  assign byte_taken  = acc;
  assign rx_enable   = live_q & (state != READY);
  assign image_ready = (state == READY);

  // live_q keeps rx_enable low for the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      taken_q <= acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (acc && is_start) state_nx = LOAD;
      LOAD:  if (acc && last_byte) state_nx = DONE_ST;
      READY: if (img_consumed) state_nx = IDLE;
`ifdef SPI_IMG_CHECKSUM_EN
      CHECK: if (acc) state_nx = chk_bad ? IDLE : READY;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_cmd = 1'b0;
    buf_we    = 1'b0;
    buf_clr   = 1'b0;
    case (state)
      IDLE: begin
        start_cmd = acc & is_start;
        buf_clr   = acc & is_clear;
      end
      LOAD: buf_we = acc;
`ifdef SPI_IMG_CHECKSUM_EN
      CHECK: buf_clr = acc & chk_bad;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (start_cmd) cnt <= '0;
    else if (buf_we)    cnt <= cnt + 1'b1;
  end

`ifdef SPI_IMG_CHECKSUM_EN
  assign chk_bad = (spi_rx_data != xsum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_cmd)   xsum <= '0;
      else if (buf_we) xsum <= xsum ^ spi_rx_data;
      if (start_cmd)                            err_q <= 1'b0;
      else if (state == CHECK && acc && chk_bad) err_q <= 1'b1;
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

  img_bit_buffer #(.NPIX(NPIX)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .widx  (cnt),
    .wdata (spi_rx_data),
    .clr   (buf_clr),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: doc/spi_image_loader.md
# spi_image_loader

Downstream consumer of the SPI byte receiver in the binary-neural-network OCR datapath. Parses the received byte stream for a start command, then unpacks a fixed-size frame of 1-bit pixels into an internal bit buffer. Once the frame is complete it raises `image_ready` and presents a registered random-access pixel read port to the BNN inference engine. It gates the receiver through `rx_enable` until the engine releases the frame.

## Interface
- `IMG_W`, 16: image width in pixels.
- `IMG_H`, 16: image height in pixels. `IMG_W*IMG_H` must be a multiple of 8.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high. The block has one clock. Reset is asynchronous and active-high.
- `spi_rx_data`  in  8: received byte from the SPI receiver.
- `byte_valid`  in  1: receiver holds a byte. Stays high until taken, plus one trailing cycle.
- `byte_taken`  out  1: single-cycle pulse that consumes the current byte.
- `rx_enable`  out  1: permits the receiver to start a new byte.
- `image_ready`  out  1: a complete frame is held in the buffer.
- `img_consumed`  in  1: engine pulse that releases the frame.
- `frame_err`  out  1: sticky error flag. Cleared by the next START or by reset.
- `rd_addr`  in  `$clog2(IMG_W*IMG_H)`: pixel index, row-major.
- `rd_data`  out  1: pixel at `rd_addr`.

## Operation
- Derived constant: IMG_BYTES = IMG_W*IMG_H/8. Default is 32.
- States:
  - IDLE: `rx_enable`=1. Accepted byte 0xA5 (START) → LOAD, with byte count cleared and `frame_err` cleared. Accepted 0x5A (CLEAR) → zero the buffer and stay in IDLE. Any other byte is consumed and discarded.
  - LOAD: `rx_enable`=1. Each accepted byte is written to pixels 8k..8k+7, MSB first; bit 7 maps to pixel 8k. The count increments. The byte with count = IMG_BYTES-1 → READY (or CHECK, see Configuration). Command values are not decoded in LOAD; 0xA5 and 0x5A are pixel data.
  - READY: `rx_enable`=0 and `image_ready`=1. `img_consumed` → IDLE. Bytes that arrive are not taken; they stay pending in the receiver.
- Accept rule: a byte is accepted when `byte_valid`=1 and `byte_taken` was not asserted in the previous cycle. This one-cycle holdoff masks the receiver's trailing `byte_valid`. Each accepted byte produces exactly one `byte_taken` pulse in the same cycle.
- Back-to-back acceptance is therefore limited to one byte every 2 cycles. This is far above the SPI byte rate.
- Buffer contents are retained across frames and are overwritten in full by each frame.
- `img_consumed` is ignored outside READY.

## Timing
- Reset values: `byte_taken`=0, `rx_enable`=0 (asserted from the first cycle after reset release), `image_ready`=0, `frame_err`=0, `rd_data`=0, state IDLE, count 0, buffer all zeros.
- `byte_taken` is combinational from the accept condition.
- The buffer write happens on the acceptance clock edge.
- `image_ready` rises on the cycle after the last data byte is accepted.
- `rd_data` is registered with 1-cycle latency and is valid in any state. During LOAD it reflects partially written data.
- `rx_enable` falls in the same cycle `image_ready` rises.
- `img_consumed` and an accept in the same cycle: only possible in READY, where no accept occurs, so READY → IDLE applies.
- Reset mid-LOAD discards the partial frame and clears the buffer.

## Configuration
- `SPI_IMG_CHECKSUM_EN` defined:
  - After the last data byte, the FSM enters CHECK and accepts one more byte.
  - If that byte equals the XOR of all IMG_BYTES data bytes → READY.
  - Otherwise the block sets `frame_err`, zeroes the buffer and returns to IDLE.
- `SPI_IMG_CHECKSUM_EN` undefined: no CHECK state and no XOR register. `frame_err` is tied to 0.

## Structure
- Package `spi_img_pkg` holds:
  - the state enum `img_state_t` (IDLE, LOAD, READY, CHECK);
  - `CMD_START`=8'hA5;
  - `CMD_CLEAR`=8'h5A.
- Sub-module `img_bit_buffer` is a parameterised bit-addressable store. It provides:
  - an 8-bit byte write port (byte index, data);
  - a synchronous clear;
  - a 1-bit registered read port.
- The FSM, accept logic and counter live in the top module.

## Test plan
- After reset, assert `byte_valid` with 0x33 for 3 cycles → exactly one `byte_taken` pulse, state remains IDLE, `image_ready`=0.
- Send 0xA5, then bytes 0x00..0x1F → `image_ready`=1 one cycle after the last byte is taken. `rd_addr`=8*3+6 returns 1 (0x03, bit 1); `rd_addr`=0 returns 0. `rx_enable`=0.
- While in READY, present byte 0x11 → no `byte_taken`. Pulse `img_consumed` → IDLE, `rx_enable`=1, the pending 0x11 is taken and discarded.
- Load a frame of all 0xFF, release it, send 0x5A → every `rd_addr` reads 0.
- Assert `rst` after 10 data bytes → all outputs return to their reset values. A subsequent full frame loads correctly from pixel 0.
- With `SPI_IMG_CHECKSUM_EN`:
  - 32 bytes of 0x01 followed by 0x00 → READY.
  - 32 bytes of 0x01 followed by 0x01 → `frame_err`=1, buffer zeroed, state IDLE.
